// File: rtl/fetch_unit.sv
// ------------------------------------------------------------------
// fetch_unit : PC, credit-limited imem requests, in-order instr FIFO
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted
);

  localparam int          AW    = $clog2(DEPTH);
  localparam int          CW    = AW + 1;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [CW:0] CAP   = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [31:0]   side_pc_q    [DEPTH];
  logic [AW-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d;
  logic [AW-1:0] s_rd_q, s_rd_d, s_wr_q, s_wr_d;
  logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic          halted_q, halted_d;

  logic          w_req_fire, w_push, w_drop, w_pop;
  logic [CW:0]   w_credit_used;

  // Buffered plus in-flight words may never exceed the FIFO depth.
  assign w_credit_used  = {1'b0, count_q} + {1'b0, out_q};
  assign imem_req_valid = !rst && !halted_q && !redirect_valid &&
                          (drop_q == '0) && (w_credit_used < CAP);
  assign imem_req_addr  = pc_q;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_push = imem_resp_valid && !redirect_valid && (drop_q == '0);
  assign w_drop = imem_resp_valid && !redirect_valid && (drop_q != '0);

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? fifo_instr_q[f_rd_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[f_rd_q]    : '0;
  assign halted      = halted_q;
  assign w_pop       = instr_valid && instr_ready;

  always_comb begin
    pc_d     = pc_q;
    f_rd_d   = f_rd_q;
    f_wr_d   = f_wr_q;
    s_rd_d   = s_rd_q;
    s_wr_d   = s_wr_q;
    count_d  = count_q;
    out_d    = out_q;
    drop_d   = drop_q;
    halted_d = halted_q;
    if (redirect_valid) begin
      // Everything still in flight turns stale, minus a response landing now.
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      f_rd_d   = '0;
      f_wr_d   = '0;
      s_rd_d   = '0;
      s_wr_d   = '0;
      count_d  = '0;
      out_d    = '0;
      drop_d   = drop_q + out_q - CW'(imem_resp_valid);
      halted_d = 1'b0;
    end else begin
      if (w_req_fire) begin
        pc_d   = pc_q + 32'd4;
        s_wr_d = s_wr_q + AW'(1);
      end
      if (w_push) begin
        f_wr_d = f_wr_q + AW'(1);
        s_rd_d = s_rd_q + AW'(1);
      end
      if (w_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (w_pop) begin
        f_rd_d = f_rd_q + AW'(1);
        if (instr == ECALL) begin
          halted_d = 1'b1;
        end
      end
      count_d = count_q + CW'(w_push) - CW'(w_pop);
      out_d   = out_q + CW'(w_req_fire) - CW'(w_push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      f_rd_q   <= '0;
      f_wr_q   <= '0;
      s_rd_q   <= '0;
      s_wr_q   <= '0;
      count_q  <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      f_rd_q   <= f_rd_d;
      f_wr_q   <= f_wr_d;
      s_rd_q   <= s_rd_d;
      s_wr_q   <= s_wr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      fifo_instr_q[f_wr_q] <= imem_resp_data;
      fifo_pc_q[f_wr_q]    <= side_pc_q[s_rd_q];
    end
    if (!rst && w_req_fire) begin
      side_pc_q[s_wr_q] <= pc_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ------------------------------------------------------------------
// tb_fetch_unit : queue-level reference model, in-order imem, directed phases
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] WPC   = 32'hFFFF_FFF8;

  typedef struct packed { logic [31:0] i; logic [31:0] p; } ent_t;
  typedef struct packed { int due; logic [31:0] d; } mreq_t;

  logic        clk;
  logic        rst, req_valid, req_ready, resp_v, redir_v, iv, ir, halted;
  logic [31:0] req_addr, resp_d, redir_pc, ins, ipc;
  logic        rst2, rv2, rdy2, resp2_v, redir2_v, iv2, ir2, h2;
  logic [31:0] addr2, resp2_d, redir2_pc, i2, ipc2;

  int          total = 0, bad = 0, cyc = 0, lat = 1;
  int          first_acc = -1, first_iv = -1, ecall_pop = -1;
  bit          chk_en = 0, ecall_en = 0;

  logic [31:0] m_pc;
  ent_t        m_fifo[$];
  logic [31:0] m_pend[$];
  int          m_drop;
  bit          m_halt;
  mreq_t       mem_q[$];
  logic [31:0] req_log[$], got_pc[$], acc2_log[$];

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_v), .imem_resp_data(resp_d),
    .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .instr_valid(iv), .instr_ready(ir), .instr(ins), .instr_pc(ipc), .halted(halted)
  );

  fetch_unit #(.RESET_PC(WPC), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst2),
    .imem_req_valid(rv2), .imem_req_ready(rdy2), .imem_req_addr(addr2),
    .imem_resp_valid(resp2_v), .imem_resp_data(resp2_d),
    .redirect_valid(redir2_v), .redirect_pc(redir2_pc),
    .instr_valid(iv2), .instr_ready(ir2), .instr(i2), .instr_pc(ipc2), .halted(h2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (ecall_en && a == 32'h8) return ECALL;
    return (a << 8) | 32'h13;
  endfunction

  function automatic bit exp_rv();
    return !rst && !m_halt && !redir_v && m_drop == 0 &&
           (m_fifo.size() + m_pend.size()) < DEPTH;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Memory + reference model: state advances on each edge from the inputs seen in that cycle.
  always @(posedge clk) begin : p_model
    ent_t e;
    bit   fire, pop;
    if (!rst && iv && ir) begin
      got_pc.push_back(ipc);
      if (ins == ECALL) ecall_pop = cyc;
    end
    if (!rst && iv && first_iv < 0) first_iv = cyc;
    if (req_valid && req_ready) begin
      if (first_acc < 0) first_acc = cyc;
      req_log.push_back(req_addr);
      mem_q.push_back('{due: cyc + lat, d: mem_data(req_addr)});
    end
    if (rst) begin
      m_pc   = 32'h0;
      m_drop = 0;
      m_halt = 0;
      m_fifo.delete();
      m_pend.delete();
      mem_q.delete();
      chk_en = 1;
    end else begin
      fire = exp_rv() && req_ready;
      pop  = (m_fifo.size() > 0) && ir;
      if (redir_v) begin
        m_drop = m_drop + m_pend.size() - (resp_v ? 1 : 0);
        m_pend.delete();
        m_fifo.delete();
        m_pc   = redir_pc & 32'hFFFF_FFFC;
        m_halt = 0;
      end else begin
        if (pop) begin
          e = m_fifo.pop_front();
          if (e.i == ECALL) m_halt = 1;
        end
        if (resp_v) begin
          if (m_drop > 0) m_drop--;
          else if (m_pend.size() > 0) m_fifo.push_back('{i: resp_d, p: m_pend.pop_front()});
        end
        if (fire) begin
          m_pend.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      resp_v = 1'b1;
      resp_d = mem_q[0].d;
      void'(mem_q.pop_front());
    end else begin
      resp_v = 1'b0;
      resp_d = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_valid",   32'(req_valid), 32'(exp_rv()));
      chk("req_addr",    req_addr, m_pc);
      chk("instr_valid", 32'(iv), 32'(m_fifo.size() > 0));
      chk("instr",       ins, (m_fifo.size() > 0) ? m_fifo[0].i : 32'h0);
      chk("instr_pc",    ipc, (m_fifo.size() > 0) ? m_fifo[0].p : 32'h0);
      chk("halted",      32'(halted), 32'(m_halt));
    end
  end

  // Second instance: one-cycle memory returning the address as data.
  always @(posedge clk) begin : p_wrap
    bit          acc;
    logic [31:0] a;
    acc = rv2 && rdy2;
    a   = addr2;
    if (acc) acc2_log.push_back(a);
    #1;
    resp2_v = acc;
    resp2_d = a;
  end

  initial begin
    int  gmark, rmark, nreq, hc;
    bit  found, ok;
    rst = 1; req_ready = 1; ir = 1; redir_v = 0; redir_pc = 0; resp_v = 0; resp_d = 0;
    rst2 = 1; rdy2 = 1; ir2 = 1; redir2_v = 0; redir2_pc = 0; resp2_v = 0; resp2_d = 0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 32'h0);
    chk("rst_instr_valid", 32'(iv), 32'h0);
    chk("rst_instr", ins, 32'h0);
    chk("rst_instr_pc", ipc, 32'h0);
    chk("rst_addr", req_addr, 32'h0);
    @(posedge clk); #2 rst = 0;

    // streaming, 1-cycle memory
    step(12);
    chk("first_valid_latency", 32'(first_iv - first_acc), 32'd2);
    chk("req_addr0", qget(req_log, 0), 32'h0);
    chk("req_addr1", qget(req_log, 1), 32'h4);
    chk("req_addr2", qget(req_log, 2), 32'h8);
    chk("got_pc0", qget(got_pc, 0), 32'h0);
    chk("got_pc1", qget(got_pc, 1), 32'h4);
    chk("got_pc2", qget(got_pc, 2), 32'h8);

    // decode stall
    ir = 0;
    step(6);
    chk("stall_inflight", 32'(req_log.size() - got_pc.size()), 32'(DEPTH));
    ir = 1;
    step(10);
    ok = 1;
    for (int k = 0; k < got_pc.size(); k++) if (got_pc[k] != 32'(4 * k)) ok = 0;
    chk("seq_no_loss", 32'(ok), 32'h1);

    // redirect with two requests outstanding, 3-cycle memory
    lat = 3;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1);
      if (mem_q.size() == 2) found = 1;
    end
    chk("two_outstanding_seen", 32'(found), 32'h1);
    rmark = req_log.size(); gmark = got_pc.size();
    redir_v = 1; redir_pc = 32'h103;
    step(1);
    redir_v = 0;
    step(15);
    chk("redir_req_addr", qget(req_log, rmark), 32'h100);
    chk("redir_first_pc", qget(got_pc, gmark), 32'h100);

    // redirect colliding with a response and a handshake
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (resp_v && iv && ir) found = 1;
    end
    chk("collision_seen", 32'(found), 32'h1);
    #1;
    gmark = got_pc.size();
    redir_v = 1; redir_pc = 32'h200;
    @(posedge clk); #2 redir_v = 0;
    chk("collision_handshake", 32'(got_pc.size()), 32'(gmark + 1));
    @(negedge clk);
    chk("collision_empty", 32'(iv), 32'h0);

    // ECALL at 0x8
    step(5);
    ecall_en = 1;
    redir_v = 1; redir_pc = 32'h0;
    step(1);
    redir_v = 0;
    found = 0; hc = -1;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (halted === 1'b1) begin found = 1; hc = cyc; end
    end
    chk("halt_seen", 32'(found), 32'h1);
    chk("halt_timing", 32'(hc), 32'(ecall_pop + 1));
    @(posedge clk); #2;
    nreq = req_log.size();
    step(10);
    chk("halt_no_requests", 32'(req_log.size()), 32'(nreq));
    ecall_en = 0;
    rmark = req_log.size();
    redir_v = 1; redir_pc = 32'h40;
    step(1);
    redir_v = 0;
    @(negedge clk);
    chk("halt_cleared", 32'(halted), 32'h0);
    step(6);
    chk("resume_addr", qget(req_log, rmark), 32'h40);

    // reset mid-stream
    step(4);
    rst = 1;
    step(1);
    rst = 0;
    lat = 2;
    @(negedge clk);
    chk("midrst_addr", req_addr, 32'h0);
    chk("midrst_empty", 32'(iv), 32'h0);

    // back-pressure on both sides, 2-cycle memory
    for (int k = 0; k < 24; k++) begin
      step(1);
      req_ready = (k % 2 == 0);
      ir = (k % 3 != 0);
    end
    req_ready = 1; ir = 1;
    step(10);

    // wrap-around reset PC instance
    rst2 = 0;
    step(10);
    chk("wrap_addr0", qget(acc2_log, 0), WPC);
    chk("wrap_addr1", qget(acc2_log, 1), 32'hFFFF_FFFC);
    chk("wrap_addr2", qget(acc2_log, 2), 32'h0000_0000);
    chk("wrap_addr3", qget(acc2_log, 3), 32'h0000_0004);
    rst2 = 1;
    step(1);
    @(negedge clk);
    chk("wrap_rst_addr", addr2, WPC);
    chk("wrap_rst_empty", 32'(iv2), 32'h0);
    @(posedge clk); #2;
    rmark = acc2_log.size();
    rst2 = 0;
    step(3);
    chk("wrap_restart", qget(acc2_log, rmark), WPC);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the 32-bit instruction stream consumed by the decode controller. Keeps the PC, issues word requests to instruction memory, buffers returned words in a small in-order FIFO, and presents them to decode with a valid/ready handshake. Supports PC redirect with flush of in-flight fetches, and halts fetch once an ECALL has been handed to decode.

## Interface

- RESET_PC, 32'h0000_0000: PC loaded on reset.
- DEPTH, 2: FIFO entries; also the cap on buffered plus outstanding fetches (power of two, ≥2).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  `WORD  fetch address (always equals PC).
- imem_resp_valid  in  1  read data returned; in order, latency ≥1 cycle, never stalled.
- imem_resp_data  in  `WORD  returned instruction word.
- redirect_valid  in  1  replace PC and flush (branch/jump/trap).
- redirect_pc  in  `WORD  new PC; bits [1:0] ignored (forced 0).
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr_ready  in  1  decode accepts this cycle.
- instr  out  `WORD  instruction at FIFO head.
- instr_pc  out  `WORD  PC of that instruction.
- halted  out  1  an ECALL was consumed; fetch stopped.

## Operation

- State: pc (`WORD), FIFO of {instr, pc} × DEPTH, outstanding count, drop count, halted flag. Counters are $clog2(DEPTH)+1 bits.
- Request issue: imem_req_valid = !rst && !halted && !redirect_valid && drop == 0 && (occupancy + outstanding) < DEPTH. On accept (valid && ready), pc ← pc + 4 modulo 2^32 and outstanding increments.
- Response: when imem_resp_valid arrives with drop > 0, the word is discarded and drop decrements. Otherwise {resp_data, PC of the oldest outstanding request} is pushed and outstanding decrements. Each in-flight request's PC is tracked in a DEPTH-entry side queue. The credit rule guarantees the FIFO never overflows.
- Decode handshake: pop on instr_valid && instr_ready. instr_valid = FIFO non-empty. Push and pop in the same cycle are both allowed, including when full.
- ECALL: popped word == 32'h0000_0073 sets halted next cycle. Requests already outstanding still complete into the FIFO. halted clears only on rst or redirect.
- Redirect (highest priority):
  - pc ← {redirect_pc[31:2], 2'b00}.
  - FIFO emptied.
  - drop ← outstanding minus 1 if a response arrives this cycle; that response is itself discarded.
  - outstanding ← 0.
  - halted ← 0.
  - A decode handshake in the same cycle still completes, but an ECALL consumed that cycle does not set halted.
- Reset: pc = RESET_PC, FIFO empty, outstanding = drop = 0, halted = 0. rst takes priority over redirect and everything else.

## Timing

- Reset outputs: imem_req_valid 0 while rst high. instr_valid 0, halted 0, instr and instr_pc 0. imem_req_addr = RESET_PC.
- First request: imem_req_valid = 1 in the first cycle after rst falls.
- Response to decode: instr_valid rises the cycle after imem_resp_valid (registered FIFO). Minimum request-accept to instr_valid is memory latency + 1.
- Redirect at cycle N: imem_req_valid = 0 in N. A request to redirect_pc is issued at N+1 if no drops are pending; otherwise it follows the last stale response. instr_valid = 0 from N+1 until new data lands.
- Throughput: one instruction per cycle sustained when DEPTH ≥ memory latency + 1 and decode is always ready.
- ECALL popped at cycle N: halted = 1 and imem_req_valid = 0 from N+1.

## Test plan

- Reset, 1-cycle memory, instr_ready = 1, memory returns 32'h0000_0013 (NOP) → requests at 0x0, 0x4, 0x8…. instr_valid is first high 2 cycles after the first accept. instr_pc runs 0x0, 0x4, 0x8 with no gaps.
- Decode stalls (instr_ready = 0) for 6 cycles → at most DEPTH words buffered plus in flight. No word is lost or duplicated. Order and pc pairing are preserved on release.
- Redirect to 0x103 with 2 requests outstanding, 3-cycle memory → the next request address is 0x100. Both stale responses are dropped. The first instr_pc after redirect is 0x100.
- Redirect in the same cycle as an imem_resp_valid and an instr handshake → the handshake completes, the response is discarded, and the FIFO is empty the next cycle.
- Memory returns 32'h0000_0073 at pc 0x8 → halted = 1 the cycle after the pop. No further requests are issued. A redirect to 0x40 clears halted and fetch resumes at 0x40.
- RESET_PC = 32'hFFFF_FFF8, 4 fetches → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4. Asserting rst mid-stream returns pc to RESET_PC and the FIFO to empty the next cycle.
